// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the multicycle CPU's memory responder.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  typedef enum logic {
    PORT_IF,
    PORT_DM
  } port_t;

  localparam int unsigned LATENCY_MAX = 15;
  localparam int unsigned CNT_W       = 4;

  // Misaligned, or any address bit above the word index set.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned idx_w);
    logic [31:0] upper;
    upper = addr >> (idx_w + 2);
    return (addr[1:0] != 2'b00) || (upper != '0);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM: one write enable, registered read (read-first).
module mem_array #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Unified instruction/data memory responder: arbitrates the fetch and data
// ports, inserts LATENCY wait states, then acks with read data or a commit.
module mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              dm_err,
  output logic              if_err,
  output logic              busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  port_t             port_q;
  logic              we_q;
  logic              err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;

  logic              req_any;
  logic              accept;
  logic [31:0]       sel_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  assign req_any  = dm_req | if_req;
  assign sel_addr = dm_req ? dm_addr : if_addr;
  // Acceptance is also possible on the edge leaving ACK, so a held request
  // gets one access per LATENCY+2 cycles.
  assign accept   = ((state == IDLE) || (state == ACK)) && req_any;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      port_q  <= PORT_IF;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        port_q  <= dm_req ? PORT_DM : PORT_IF;
        we_q    <= dm_req & dm_we;
        err_q   <= addr_err(sel_addr, IDX_W);
        idx_q   <= sel_addr[IDX_W+1:2];
        wdata_q <= dm_wdata;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (req_any) begin
          state_next = WAIT;
          cnt_next   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else begin
          state_next = ACK;
        end
      end
      ACK: begin
        if (req_any) begin
          state_next = WAIT;
          cnt_next   = CNT_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Commit on the edge entering ACK; reset on that edge abandons the write.
  assign ram_we = (state == WAIT) && (cnt == '0) && we_q && !err_q && !reset;

  mem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_mem_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (ram_q)
  );

  assign busy     = (state != IDLE);
  assign dm_ack   = (state == ACK) && (port_q == PORT_DM);
  assign if_ack   = (state == ACK) && (port_q == PORT_IF);
  assign dm_err   = dm_ack && err_q;
  assign if_err   = if_ack && err_q;
  assign dm_rdata = (dm_ack && !err_q && !we_q) ? ram_q : '0;
  assign if_rdata = (if_ack && !err_q) ? ram_q : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: instance 0 with LATENCY=2, instance 1 with LATENCY=0,
// checked against a word-array model of the memory.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req   [2];
  logic [31:0] if_addr  [2];
  logic [31:0] if_rdata [2];
  logic        if_ack   [2];
  logic        dm_req   [2];
  logic        dm_we    [2];
  logic [31:0] dm_addr  [2];
  logic [31:0] dm_wdata [2];
  logic [31:0] dm_rdata [2];
  logic        dm_ack   [2];
  logic        dm_err   [2];
  logic        if_err   [2];
  logic        busy     [2];

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [31:0] ref_mem [2][256];

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(32), .DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_ack(if_ack[0]),
    .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
    .dm_rdata(dm_rdata[0]), .dm_ack(dm_ack[0]), .dm_err(dm_err[0]), .if_err(if_err[0]),
    .busy(busy[0])
  );

  mem_responder #(.DATA_W(32), .DEPTH_WORDS(256), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_ack(if_ack[1]),
    .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
    .dm_rdata(dm_rdata[1]), .dm_ack(dm_ack[1]), .dm_err(dm_err[1]), .if_err(if_err[1]),
    .busy(busy[1])
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int unsigned lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit is_err(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr >= 32'd1024);
  endfunction

  task automatic check_idle_outputs(input int d, input string tag);
    chk({tag, "_if_ack"},   {31'b0, if_ack[d]},   32'd0);
    chk({tag, "_dm_ack"},   {31'b0, dm_ack[d]},   32'd0);
    chk({tag, "_if_err"},   {31'b0, if_err[d]},   32'd0);
    chk({tag, "_dm_err"},   {31'b0, dm_err[d]},   32'd0);
    chk({tag, "_if_rdata"}, if_rdata[d],          32'd0);
    chk({tag, "_dm_rdata"}, dm_rdata[d],          32'd0);
    chk({tag, "_busy"},     {31'b0, busy[d]},     32'd0);
  endtask

  // One access; request is raised now and accepted at the next edge.
  task automatic access(input int d, input bit dm, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit scramble, input string tag);
    int unsigned lat;
    bit          err;
    bit          seen;
    int unsigned n;
    logic [31:0] exp_rd;
    logic [7:0]  widx;
    lat    = lat_of(d);
    err    = is_err(addr);
    widx   = addr[9:2];
    exp_rd = (err || (dm && we)) ? 32'd0 : ref_mem[d][widx];
    if (dm) begin
      dm_req[d] = 1'b1; dm_we[d] = we; dm_addr[d] = addr; dm_wdata[d] = wdata;
    end else begin
      if_req[d] = 1'b1; if_addr[d] = addr;
    end
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 40) begin
      cyc();
      n++;
      if (scramble && n == 1) begin
        dm_addr[d] = addr + 32'd4; if_addr[d] = addr + 32'd4;
        dm_wdata[d] = 32'd0; dm_we[d] = ~we;
      end
      chk({tag, "_busy"}, {31'b0, busy[d]}, 32'd1);
      seen = dm ? dm_ack[d] : if_ack[d];
    end
    chk({tag, "_cycles"}, n, lat + 2);
    if (dm) begin
      chk({tag, "_err"}, {31'b0, dm_err[d]}, {31'b0, err});
      if (!we) chk({tag, "_rdata"}, dm_rdata[d], exp_rd);
      chk({tag, "_other_ack"}, {31'b0, if_ack[d]}, 32'd0);
      chk({tag, "_other_rd"}, if_rdata[d], 32'd0);
    end else begin
      chk({tag, "_err"}, {31'b0, if_err[d]}, {31'b0, err});
      chk({tag, "_rdata"}, if_rdata[d], exp_rd);
      chk({tag, "_other_ack"}, {31'b0, dm_ack[d]}, 32'd0);
      chk({tag, "_other_rd"}, dm_rdata[d], 32'd0);
    end
    dm_req[d] = 1'b0;
    if_req[d] = 1'b0;
    if (dm && we && !err) ref_mem[d][widx] = wdata;
  endtask

  // Fetch and data read raised together: data must win, fetch follows.
  task automatic simul(input int d, input logic [31:0] faddr, input logic [31:0] daddr);
    int unsigned lat;
    int unsigned n;
    int unsigned t_dm;
    int unsigned t_if;
    logic [7:0]  fi;
    logic [7:0]  di;
    lat = lat_of(d);
    fi  = faddr[9:2];
    di  = daddr[9:2];
    t_dm = 0; t_if = 0; n = 0;
    if_req[d] = 1'b1; if_addr[d] = faddr;
    dm_req[d] = 1'b1; dm_we[d] = 1'b0; dm_addr[d] = daddr;
    while (t_if == 0 && n < 60) begin
      cyc();
      n++;
      if (dm_ack[d]) begin
        t_dm = n;
        chk("sim_dm_rdata", dm_rdata[d], ref_mem[d][di]);
        chk("sim_if_ack_quiet", {31'b0, if_ack[d]}, 32'd0);
        chk("sim_if_rdata_quiet", if_rdata[d], 32'd0);
        dm_req[d] = 1'b0;
      end
      if (if_ack[d]) begin
        t_if = n;
        chk("sim_if_rdata", if_rdata[d], ref_mem[d][fi]);
        chk("sim_dm_ack_quiet", {31'b0, dm_ack[d]}, 32'd0);
        if_req[d] = 1'b0;
      end
    end
    chk("sim_dm_cycles", t_dm, lat + 2);
    chk("sim_if_gap", t_if - t_dm, lat + 2);
    if_req[d] = 1'b0;
    dm_req[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int unsigned r;
    int          d;
    for (int i = 0; i < 2; i++) begin
      if_req[i] = 1'b0; if_addr[i] = '0; dm_req[i] = 1'b0;
      dm_we[i] = 1'b0; dm_addr[i] = '0; dm_wdata[i] = '0;
    end
    reset = 1'b1;
    cyc(); cyc();
    check_idle_outputs(0, "rst0");
    check_idle_outputs(1, "rst1");
    reset = 1'b0;
    cyc();

    // Known contents for words 0..15 on both instances
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 16; w++)
        access(k, 1'b1, 1'b1, 32'(w * 4), $urandom, 1'b0, "init");

    // Write then read back, LATENCY=2
    access(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "wr10");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "rd10");
    chk("rd10_model", ref_mem[0][4], 32'hDEADBEEF);

    // Fetch with LATENCY=0
    access(1, 1'b1, 1'b1, 32'h0, 32'h08000004, 1'b0, "pre0");
    access(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, "fetch0");

    simul(0, 32'h4, 32'h10);
    simul(1, 32'h4, 32'h10);

    // Error accesses
    access(0, 1'b1, 1'b1, 32'h13, 32'h12345678, 1'b0, "wr_mis");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "rd10_after_mis");
    access(0, 1'b1, 1'b0, 32'h400, 32'h0, 1'b0, "rd_oor");
    access(0, 1'b0, 1'b0, 32'h802, 32'h0, 1'b0, "if_err");

    // Reset on the very edge that would commit a write to 0x20
    access(0, 1'b1, 1'b1, 32'h20, 32'h11111111, 1'b0, "wr20");
    cyc();
    dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 32'h20; dm_wdata[0] = 32'h22222222;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("rstmid_noack", {31'b0, dm_ack[0]}, 32'd0);
    end
    reset = 1'b1;
    dm_req[0] = 1'b0;
    cyc();
    check_idle_outputs(0, "rstmid");
    reset = 1'b0;
    cyc();
    check_idle_outputs(0, "rstmid_idle");
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, "rd20");

    // Inputs changing during WAIT must be ignored
    access(0, 1'b1, 1'b1, 32'h24, 32'hA5A5A5A5, 1'b1, "wr24_scr");
    access(0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, "rd24");
    access(0, 1'b1, 1'b0, 32'h28, 32'h0, 1'b0, "rd28");

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      d = int'($urandom_range(1, 0));
      r = $urandom_range(9, 0);
      if (r == 0)      a = 32'($urandom_range(15, 0) * 4 + $urandom_range(3, 1));
      else if (r == 1) a = {$urandom_range(255, 1), 10'h0} | 32'($urandom_range(15, 0) * 4);
      else             a = 32'($urandom_range(15, 0) * 4);
      access(d, $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, a, $urandom, 1'b0, "rand");
      if ($urandom_range(1, 0) == 1) cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
